// File: rtl/rx_pkg.sv
// Shared types and constants for the receive-side byte-to-word assembler.
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } rx_state_t;

    localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/rx_assembler_if.sv
// Byte-receive / RAM-write bundle of the rx_assembler; master is the assembler side.
interface rx_assembler_if #(
    parameter int unsigned MAX_ADDR = 1024,
    parameter int unsigned DATA_W   = 32
);
    localparam int unsigned AW = (MAX_ADDR > 1) ? $clog2(MAX_ADDR) : 1;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              in_mode;
    logic [1:0]        max_pck;
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_en;
    logic              done;
    logic              timeout;
    logic              busy;

    modport master (
        input  rx_data, rx_valid, in_mode, max_pck,
        output w_addr, w_data, w_en, done, timeout, busy
    );

    modport slave (
        output rx_data, rx_valid, in_mode, max_pck,
        input  w_addr, w_data, w_en, done, timeout, busy
    );

endinterface

// File: rtl/rx_timeout_ctr.sv
// Inter-byte idle counter: clears on clr, counts while en, flags the terminal cycle.
module rx_timeout_ctr #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // tc is combinational so the FSM acts on the same edge the count is exhausted
    assign tc = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr || tc) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rx_assembler.sv
// Packs 1-4 received bytes (LSB first) into memory words and writes them at incrementing addresses.
module rx_assembler
    import rx_pkg::*;
#(
    parameter int unsigned MAX_ADDR = 1024,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TIMEOUT  = 100000
) (
    input logic            clk,
    input logic            rst,
    rx_assembler_if.master bus
);
    localparam int unsigned AW = (MAX_ADDR > 1) ? $clog2(MAX_ADDR) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(MAX_ADDR - 1);

    rx_state_t         state;
    logic [1:0]        byte_cnt;
    logic [1:0]        pck_q;
    logic              mode_q;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] word;
    logic              w_en_q;
    logic              done_q;
    logic              timeout_q;
    logic              busy_q;
    logic              tmo_hit;

    rx_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk(clk),
        .rst(rst),
        .clr(bus.rx_valid || (state != COLLECT)),
        .en ((state == COLLECT) && !bus.rx_valid),
        .tc (tmo_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            pck_q     <= '0;
            mode_q    <= 1'b0;
            addr      <= '0;
            word      <= '0;
            w_en_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            w_en_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    byte_cnt <= '0;
                    word     <= '0;
                    addr     <= '0;
                    busy_q   <= 1'b0;
                    if (bus.rx_valid) begin
                        pck_q    <= bus.max_pck;
                        mode_q   <= bus.in_mode;
                        word     <= DATA_W'(bus.rx_data);
                        byte_cnt <= 2'd1;
                        busy_q   <= 1'b1;
                        if (bus.max_pck == 2'd0) begin
                            state  <= WRITE;
                            w_en_q <= 1'b1;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (tmo_hit) begin
                        state     <= IDLE;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        byte_cnt  <= '0;
                        word      <= '0;
                        addr      <= '0;
                    end else if (bus.rx_valid) begin
                        // lanes are written once into a cleared word, so OR-merge suffices
                        word <= word | (DATA_W'(bus.rx_data) << {byte_cnt, 3'b000});
                        if (byte_cnt == pck_q) begin
                            state  <= WRITE;
                            w_en_q <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    byte_cnt <= '0;
                    word     <= '0;
                    if (mode_q || (addr == LAST_ADDR)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= COLLECT;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.w_addr  = addr;
    assign bus.w_data  = word;
    assign bus.w_en    = w_en_q;
    assign bus.done    = done_q;
    assign bus.timeout = timeout_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_rx_assembler.sv
// Directed bench for rx_assembler: expected RAM writes are queued at stimulus time and popped on w_en.
module tb_rx_assembler;

    localparam int unsigned MAX_ADDR = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned TIMEOUT  = 50;

    typedef struct packed {
        logic [1:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;
    int n_tmo  = 0;

    wr_t exp_q[$];
    wr_t e;

    rx_assembler_if #(.MAX_ADDR(MAX_ADDR), .DATA_W(DATA_W)) bus ();

    rx_assembler #(
        .MAX_ADDR(MAX_ADDR),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    // Write monitor and pulse counters, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.done === 1'b1) n_done++;
        if (bus.timeout === 1'b1) n_tmo++;
        if (bus.w_en === 1'b1) begin
            check("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("w_addr", bus.w_addr, e.addr);
                check("w_data", bus.w_data, e.data);
            end
            check("w_en_excl", {bus.done, bus.timeout}, 0);
        end
        if (bus.done === 1'b1) check("done_excl", bus.timeout, 0);
    end

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.in_mode  = 1'b1;
        bus.max_pck  = 2'd3;
        tick(2);
        rst = 1'b0;
        check("rst_w_addr", bus.w_addr, 0);
        check("rst_w_data", bus.w_data, 0);
        check("rst_w_en", bus.w_en, 0);
        check("rst_done", bus.done, 0);
        check("rst_timeout", bus.timeout, 0);
        check("rst_busy", bus.busy, 0);
        tick(2);

        // single word, 4 bytes
        bus.in_mode = 1'b1;
        bus.max_pck = 2'd3;
        exp_q.push_back('{addr: 2'd0, data: 32'h4433_2211});
        send_byte(8'h11);
        check("t1_busy", bus.busy, 1);
        tick(3);
        send_byte(8'h22);
        tick(3);
        send_byte(8'h33);
        check("t1_no_early_wen", bus.w_en, 0);
        tick(3);
        send_byte(8'h44);
        check("t1_wen", bus.w_en, 1);
        check("t1_wdata", bus.w_data, 32'h4433_2211);
        tick(1);
        check("t1_done", bus.done, 1);
        check("t1_wen_off", bus.w_en, 0);
        check("t1_busy_done", bus.busy, 1);
        tick(1);
        check("t1_done_off", bus.done, 0);
        check("t1_busy_off", bus.busy, 0);
        tick(2);

        // single word, 1 byte
        bus.max_pck = 2'd0;
        exp_q.push_back('{addr: 2'd0, data: 32'h0000_00A5});
        send_byte(8'hA5);
        check("t2_wen", bus.w_en, 1);
        tick(1);
        check("t2_done", bus.done, 1);
        tick(1);
        check("t2_busy_off", bus.busy, 0);
        tick(2);

        // full buffer, 2 bytes per word
        bus.in_mode = 1'b0;
        bus.max_pck = 2'd1;
        for (int w = 0; w < 4; w++) begin
            exp_q.push_back('{addr: 2'(w), data: {16'h0000, 8'(2*w+2), 8'(2*w+1)}});
            send_byte(8'(2*w+1));
            tick(2);
            send_byte(8'(2*w+2));
            check("t3_wen", bus.w_en, 1);
            tick(1);
            check("t3_done", bus.done, (w == 3) ? 1 : 0);
            tick(2);
        end
        check("t3_busy_off", bus.busy, 0);
        check("t3_done_count", n_done, 3);

        // new transfer restarts at address 0, then stalls after the first write
        exp_q.push_back('{addr: 2'd0, data: 32'h0000_0A09});
        send_byte(8'h09);
        tick(2);
        send_byte(8'h0A);
        check("t3b_wen", bus.w_en, 1);
        tick(50);
        check("t3b_no_early_tmo", bus.timeout, 0);
        tick(1);
        check("t3b_tmo", bus.timeout, 1);
        check("t3b_busy_off", bus.busy, 0);
        tick(2);

        // timeout with a partial word
        bus.in_mode = 1'b1;
        bus.max_pck = 2'd3;
        send_byte(8'hB1);
        tick(1);
        send_byte(8'hB2);
        tick(49);
        check("t4_no_early_tmo", bus.timeout, 0);
        tick(1);
        check("t4_tmo", bus.timeout, 1);
        check("t4_wen", bus.w_en, 0);
        check("t4_done", bus.done, 0);
        check("t4_addr", bus.w_addr, 0);
        tick(1);
        check("t4_tmo_off", bus.timeout, 0);
        bus.max_pck = 2'd0;
        exp_q.push_back('{addr: 2'd0, data: 32'h0000_005A});
        send_byte(8'h5A);
        check("t4_fresh_wdata", bus.w_data, 32'h0000_005A);
        tick(4);

        // max_pck latched at the first byte
        bus.max_pck = 2'd3;
        exp_q.push_back('{addr: 2'd0, data: 32'hC4C3_C2C1});
        send_byte(8'hC1);
        bus.max_pck = 2'd0;
        tick(2);
        send_byte(8'hC2);
        check("t5_latch_c2", bus.w_en, 0);
        tick(2);
        send_byte(8'hC3);
        check("t5_latch_c3", bus.w_en, 0);
        tick(2);
        send_byte(8'hC4);
        check("t5_wen", bus.w_en, 1);
        tick(4);
        exp_q.push_back('{addr: 2'd0, data: 32'h0000_007E});
        send_byte(8'h7E);
        check("t5_next_1byte", bus.w_en, 1);
        tick(4);

        // reset mid-transfer
        bus.max_pck = 2'd3;
        send_byte(8'hD1);
        tick(1);
        send_byte(8'hD2);
        tick(1);
        rst = 1'b1;
        tick(1);
        check("t6_w_addr", bus.w_addr, 0);
        check("t6_w_data", bus.w_data, 0);
        check("t6_w_en", bus.w_en, 0);
        check("t6_done", bus.done, 0);
        check("t6_timeout", bus.timeout, 0);
        check("t6_busy", bus.busy, 0);
        rst = 1'b0;
        tick(1);
        exp_q.push_back('{addr: 2'd0, data: 32'hE4E3_E2E1});
        send_byte(8'hE1);
        tick(1);
        send_byte(8'hE2);
        tick(1);
        send_byte(8'hE3);
        tick(1);
        send_byte(8'hE4);
        check("t6_wen", bus.w_en, 1);
        check("t6_wdata", bus.w_data, 32'hE4E3_E2E1);
        tick(1);
        check("t6_done_after", bus.done, 1);
        tick(3);

        check("sb_drained", exp_q.size(), 0);
        check("done_total", n_done, 7);
        check("timeout_total", n_tmo, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
